// File: rtl/melody_sequencer.sv
// Note sequencer: steps through a writable score on fs ticks, drives pitch maxval and gate.
// Outputs are registered from next-state values so inputs never reach outputs combinationally.
module melody_sequencer #(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int DEPTH          = 32,
    parameter int ADDR_BITWIDTH  = 5,
    parameter int FS_BITWIDTH    = 7,
    parameter int GAP_BITWIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FS_BITWIDTH-1:0]    fs_maxval,
    input  logic [GAP_BITWIDTH-1:0]   gap,
    input  logic [ADDR_BITWIDTH-1:0]  length,
    input  logic                      loop,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      wr_en,
    input  logic [ADDR_BITWIDTH-1:0]  wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    output logic [PITCH_BITWIDTH-1:0] pitch_o,
    output logic                      gate_o,
    output logic [ADDR_BITWIDTH-1:0]  note_idx_o,
    output logic                      note_strobe_o,
    output logic                      fs_tick_o,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    logic [PITCH_BITWIDTH-1:0] r_mem_pitch [DEPTH];
    logic [DUR_BITWIDTH-1:0]   r_mem_dur   [DEPTH];

    state_t                    r_state, w_state_nxt;
    logic [ADDR_BITWIDTH-1:0]  r_idx, w_idx_nxt;
    logic [DUR_BITWIDTH-1:0]   r_ctr_dur, w_ctr_nxt;
    logic [PITCH_BITWIDTH-1:0] r_cur_pitch, w_cur_pitch_nxt;
    logic [DUR_BITWIDTH-1:0]   r_cur_dur, w_cur_dur_nxt;
    logic [DUR_BITWIDTH-1:0]   w_dur_eff, w_dur_eff_nxt;
    logic                      w_load, w_done_nxt, w_gate_nxt;
    logic [DUR_BITWIDTH:0]     w_gate_sum;

    logic [FS_BITWIDTH-1:0]    r_fs_cnt, w_fs_cnt_nxt, w_fs_last;
    logic                      r_fs_tick;

    logic [PITCH_BITWIDTH-1:0] r_pitch;
    logic                      r_gate, r_strobe, r_done;

    // Score memory write port; no reset so the score survives a reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_pitch[wr_addr] <= wr_pitch;
            r_mem_dur[wr_addr]   <= wr_dur;
        end
    end

    // fs divider next count; the tick flag is registered one step ahead so it lines up with the count
    always_comb begin
        w_fs_last = (fs_maxval > FS_BITWIDTH'(1)) ? (fs_maxval - FS_BITWIDTH'(1)) : '0;
        if (start) begin
            w_fs_cnt_nxt = '0;
        end else if (r_fs_cnt >= w_fs_last) begin
            w_fs_cnt_nxt = '0;
        end else begin
            w_fs_cnt_nxt = r_fs_cnt + FS_BITWIDTH'(1);
        end
    end

    // Sequencer next-state: stop beats start beats fs tick
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ctr_nxt   = r_ctr_dur;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        w_dur_eff   = (r_cur_dur == '0) ? DUR_BITWIDTH'(1) : r_cur_dur;
        if (stop) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_ctr_nxt   = '0;
        end else if (start) begin
            w_state_nxt = S_PLAY;
            w_idx_nxt   = '0;
            w_ctr_nxt   = '0;
            w_load      = 1'b1;
        end else if (r_state == S_PLAY && r_fs_tick) begin
            if (r_ctr_dur < w_dur_eff - DUR_BITWIDTH'(1)) begin
                w_ctr_nxt = r_ctr_dur + DUR_BITWIDTH'(1);
            end else if (r_idx < length) begin
                w_idx_nxt = r_idx + ADDR_BITWIDTH'(1);
                w_ctr_nxt = '0;
                w_load    = 1'b1;
            end else if (loop) begin
                w_idx_nxt = '0;
                w_ctr_nxt = '0;
                w_load    = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
                w_ctr_nxt   = '0;
                w_done_nxt  = 1'b1;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Note load reads memory before any same-edge write lands; gate compare is one bit wider to avoid wrap
    always_comb begin
        if (w_load) begin
            w_cur_pitch_nxt = r_mem_pitch[w_idx_nxt];
            w_cur_dur_nxt   = r_mem_dur[w_idx_nxt];
        end else begin
            w_cur_pitch_nxt = r_cur_pitch;
            w_cur_dur_nxt   = r_cur_dur;
        end
        w_dur_eff_nxt = (w_cur_dur_nxt == '0) ? DUR_BITWIDTH'(1) : w_cur_dur_nxt;
        w_gate_sum    = (DUR_BITWIDTH+1)'(w_ctr_nxt) + (DUR_BITWIDTH+1)'(gap);
        w_gate_nxt    = (w_state_nxt == S_PLAY) && (w_cur_pitch_nxt != '0)
                        && (w_gate_sum < (DUR_BITWIDTH+1)'(w_dur_eff_nxt));
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_ctr_dur   <= '0;
            r_cur_pitch <= '0;
            r_cur_dur   <= '0;
            r_fs_cnt    <= '0;
            r_fs_tick   <= 1'b0;
            r_pitch     <= '0;
            r_gate      <= 1'b0;
            r_strobe    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ctr_dur   <= w_ctr_nxt;
            r_cur_pitch <= w_cur_pitch_nxt;
            r_cur_dur   <= w_cur_dur_nxt;
            r_fs_cnt    <= w_fs_cnt_nxt;
            r_fs_tick   <= (w_fs_cnt_nxt == w_fs_last);
            r_pitch     <= (w_state_nxt == S_PLAY) ? w_cur_pitch_nxt : '0;
            r_gate      <= w_gate_nxt;
            r_strobe    <= w_load;
            r_done      <= w_done_nxt;
        end
    end

    assign pitch_o       = r_pitch;
    assign gate_o        = r_gate;
    assign note_idx_o    = r_idx;
    assign note_strobe_o = r_strobe;
    assign fs_tick_o     = r_fs_tick;
    assign busy_o        = (r_state == S_PLAY);
    assign done_o        = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer; cycle c is sampled on the negedge after edge c.
module tb_melody_sequencer;

    logic       clk;
    logic       reset;
    logic [6:0] fs_maxval;
    logic [7:0] gap;
    logic [4:0] length;
    logic       loop;
    logic       start;
    logic       stop;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [8:0] wr_pitch;
    logic [12:0] wr_dur;
    logic [8:0] pitch_o;
    logic       gate_o;
    logic [4:0] note_idx_o;
    logic       note_strobe_o;
    logic       fs_tick_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_errors = 0;

    melody_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .fs_maxval     (fs_maxval),
        .gap           (gap),
        .length        (length),
        .loop          (loop),
        .start         (start),
        .stop          (stop),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_pitch      (wr_pitch),
        .wr_dur        (wr_dur),
        .pitch_o       (pitch_o),
        .gate_o        (gate_o),
        .note_idx_o    (note_idx_o),
        .note_strobe_o (note_strobe_o),
        .fs_tick_o     (fs_tick_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cyc(input string sc, input int c, input logic e_strobe, input logic e_done,
                           input logic e_busy, input logic e_gate, input int e_pitch, input int e_idx);
        chk($sformatf("%s strobe@%0d", sc, c), 32'(note_strobe_o), 32'(e_strobe));
        chk($sformatf("%s done@%0d", sc, c), 32'(done_o), 32'(e_done));
        chk($sformatf("%s busy@%0d", sc, c), 32'(busy_o), 32'(e_busy));
        chk($sformatf("%s gate@%0d", sc, c), 32'(gate_o), 32'(e_gate));
        chk($sformatf("%s pitch@%0d", sc, c), 32'(pitch_o), 32'(e_pitch));
        chk($sformatf("%s idx@%0d", sc, c), 32'(note_idx_o), 32'(e_idx));
    endtask

    task automatic chk_all_zero(input string sc);
        chk({sc, " pitch"}, 32'(pitch_o), 32'd0);
        chk({sc, " gate"}, 32'(gate_o), 32'd0);
        chk({sc, " idx"}, 32'(note_idx_o), 32'd0);
        chk({sc, " strobe"}, 32'(note_strobe_o), 32'd0);
        chk({sc, " busy"}, 32'(busy_o), 32'd0);
        chk({sc, " done"}, 32'(done_o), 32'd0);
    endtask

    task automatic mem_write(input logic [4:0] a, input logic [8:0] p, input logic [12:0] d);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_pitch = p;
        wr_dur   = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int m;
        reset = 1'b0; fs_maxval = 7'd4; gap = 8'd1; length = 5'd2; loop = 1'b0;
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_pitch = 9'd0; wr_dur = 13'd0;

        // Reset state without a clock edge having occurred
        #3;
        chk_all_zero("reset");
        chk("reset fs_tick", 32'(fs_tick_o), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mem_write(5'd0, 9'd266, 13'd4);
        mem_write(5'd1, 9'd199, 13'd2);
        mem_write(5'd2, 9'd0, 13'd3);
        @(negedge clk);
        chk_all_zero("idle");

        // One-shot: strobes 0/16/24, done at 36, tick every 4th cycle
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            chk_cyc("oneshot", c, (c == 0 || c == 16 || c == 24), (c == 36), (c < 36),
                    (c < 12 || (c >= 16 && c < 20)),
                    (c < 16) ? 266 : (c < 24) ? 199 : 0,
                    (c < 16) ? 0 : (c < 24) ? 1 : (c < 36) ? 2 : 0);
            chk($sformatf("oneshot fs_tick@%0d", c), 32'(fs_tick_o), 32'(c % 4 == 3));
            @(negedge clk);
        end

        // Loop: wraps at 36 with no done; stop during note 1 of the second pass
        loop = 1'b1;
        pulse_start();
        for (int c = 0; c <= 54; c++) begin
            m = c % 36;
            chk_cyc("loop", c, (m == 0 || m == 16 || m == 24), 1'b0, 1'b1,
                    (m < 12 || (m >= 16 && m < 20)),
                    (m < 16) ? 266 : (m < 24) ? 199 : 0,
                    (m < 16) ? 0 : (m < 24) ? 1 : 2);
            if (c < 54) @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_all_zero("stop");

        // Re-start from IDLE, then restart while playing note 1
        pulse_start();
        chk_cyc("restart", 0, 1'b1, 1'b0, 1'b1, 1'b1, 266, 0);
        repeat (18) @(negedge clk);
        chk("playing pitch@18", 32'(pitch_o), 32'd199);
        chk("playing idx@18", 32'(note_idx_o), 32'd1);
        pulse_start();
        chk_cyc("restart_busy", 0, 1'b1, 1'b0, 1'b1, 1'b1, 266, 0);

        // Overwrite the playing note's pitch mid-note; visible only on its next load
        for (int c = 0; c <= 36; c++) begin
            if (c == 5 || c == 15) chk($sformatf("wrmid pitch@%0d", c), 32'(pitch_o), 32'd266);
            if (c == 36) begin
                chk("wrmid reload pitch", 32'(pitch_o), 32'd300);
                chk("wrmid reload strobe", 32'(note_strobe_o), 32'd1);
            end
            if (c == 2) begin
                wr_en = 1'b1; wr_addr = 5'd0; wr_pitch = 9'd300; wr_dur = 13'd4;
            end
            if (c == 3) wr_en = 1'b0;
            if (c < 36) @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_all_zero("stop2");

        // gap >= dur keeps gate low; dur=0 note lasts one tick
        gap = 8'd5; length = 5'd1; loop = 1'b0;
        mem_write(5'd1, 9'd199, 13'd0);
        pulse_start();
        for (int c = 0; c < 22; c++) begin
            chk_cyc("gapdur0", c, (c == 0 || c == 16), (c == 20), (c < 20), 1'b0,
                    (c < 16) ? 300 : (c < 20) ? 199 : 0,
                    (c < 16) ? 0 : (c < 20) ? 1 : 0);
            @(negedge clk);
        end

        // fs_maxval=0: a tick every cycle
        fs_maxval = 7'd0; gap = 8'd0;
        pulse_start();
        for (int c = 0; c < 7; c++) begin
            chk_cyc("fs0", c, (c == 0 || c == 4), (c == 5), (c < 5), (c < 5),
                    (c < 4) ? 300 : (c < 5) ? 199 : 0,
                    (c < 4) ? 0 : (c < 5) ? 1 : 0);
            chk($sformatf("fs0 fs_tick@%0d", c), 32'(fs_tick_o), 32'd1);
            @(negedge clk);
        end

        // Async reset between edges clears outputs at once; stays idle after release
        fs_maxval = 7'd4; gap = 8'd1; length = 5'd2;
        pulse_start();
        repeat (5) @(negedge clk);
        chk("prereset busy", 32'(busy_o), 32'd1);
        chk("prereset gate", 32'(gate_o), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        chk("async_reset fs_tick", 32'(fs_tick_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk_all_zero("post_reset_idle");
        pulse_start();
        chk_cyc("post_reset_start", 0, 1'b1, 1'b0, 1'b1, 1'b1, 300, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
